// File: rtl/reg_bus_arbiter.sv
// Two-port arbiter for a TinyQV-style peripheral register bus: round-robin grant,
// one-cycle writes, reads held until bus_ready or timeout, registered completion strobes.
module reg_bus_arbiter #(
    parameter int ADDR_W  = 6,
    parameter int DATA_W  = 32,
    parameter int TIMEOUT = 15
) (
    input  logic                   clk,
    input  logic                   rstb,
    input  logic                   ena,
    input  logic [1:0]             rq_valid,
    input  logic [1:0]             rq_rw,
    input  logic [1:0][1:0]        rq_width,
    input  logic [1:0][ADDR_W-1:0] rq_addr,
    input  logic [1:0][DATA_W-1:0] rq_wdata,
    output logic [1:0]             rq_done,
    output logic                   rq_err,
    output logic [DATA_W-1:0]      rq_rdata,
    output logic [ADDR_W-1:0]      bus_addr,
    output logic [DATA_W-1:0]      bus_wdata,
    output logic [1:0]             bus_write_n,
    output logic [1:0]             bus_read_n,
    input  logic [DATA_W-1:0]      bus_rdata,
    input  logic                   bus_ready
);

    typedef enum logic [1:0] {IDLE, WRITE, READ, DONE} state_t;

    localparam logic [7:0] TO_LAST = 8'(TIMEOUT - 1);
    localparam logic [1:0] BUS_IDLE = 2'b11;

    state_t     state;
    logic       last_grant;
    logic       grant;
    logic       sel;
    logic [7:0] count;

    // Port chosen if the FSM grants this cycle; a lone requester always wins.
    always_comb begin
        sel = rq_valid[1];
        if (rq_valid == 2'b11) sel = ~last_grant;
    end

    // NOTE: non-blocking assignments so every register sees pre-edge values of the others.
    always_ff @(posedge clk) begin
        if (!rstb) begin
            state       <= IDLE;
            last_grant  <= 1'b1;
            grant       <= 1'b0;
            count       <= '0;
            bus_addr    <= '0;
            bus_wdata   <= '0;
            bus_write_n <= BUS_IDLE;
            bus_read_n  <= BUS_IDLE;
            rq_done     <= 2'b00;
            rq_err      <= 1'b0;
            rq_rdata    <= '0;
        end else if (ena) begin
            case (state)
                IDLE: begin
                    if (rq_valid != 2'b00) begin
                        grant      <= sel;
                        last_grant <= sel;
                        bus_addr   <= rq_addr[sel];
                        bus_wdata  <= rq_wdata[sel];
                        if (rq_width[sel] == 2'b11) begin
                            state   <= DONE;
                            rq_done <= sel ? 2'b10 : 2'b01;
                            rq_err  <= 1'b1;
                        end else if (rq_rw[sel]) begin
                            state       <= WRITE;
                            bus_write_n <= rq_width[sel];
                        end else begin
                            state      <= READ;
                            bus_read_n <= rq_width[sel];
                            count      <= '0;
                        end
                    end
                end
                WRITE: begin
                    bus_write_n <= BUS_IDLE;
                    rq_done     <= grant ? 2'b10 : 2'b01;
                    rq_err      <= 1'b0;
                    state       <= DONE;
                end
                READ: begin
                    if (bus_ready) begin
                        bus_read_n <= BUS_IDLE;
                        rq_rdata   <= bus_rdata;
                        rq_done    <= grant ? 2'b10 : 2'b01;
                        rq_err     <= 1'b0;
                        state      <= DONE;
                    end else if (count == TO_LAST) begin
                        bus_read_n <= BUS_IDLE;
                        rq_rdata   <= '0;
                        rq_done    <= grant ? 2'b10 : 2'b01;
                        rq_err     <= 1'b1;
                        state      <= DONE;
                    end else begin
                        count <= count + 8'd1;
                    end
                end
                DONE: begin
                    rq_done <= 2'b00;
                    rq_err  <= 1'b0;
                    state   <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule
